uart_tx_periph: RTL and testbench



---
 rtl/uart_tx_periph_pkg.sv | 30 +++
 rtl/uart_tx_periph_fifo.sv | 57 +++++
 rtl/uart_tx_periph.sv | 122 ++++++++++++
 tb/tb_uart_tx_periph.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the UART TX peripheral: register offsets, STATUS layout, FSM states.
package uart_tx_periph_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;

    localparam int unsigned ST_BUSY  = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_EMPTY = 2;
    localparam int unsigned ST_COUNT = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                                input logic empty, input logic [3:0] cnt);
        logic [31:0] s;
        s              = '0;
        s[ST_BUSY]     = busy;
        s[ST_FULL]     = full;
        s[ST_EMPTY]    = empty;
        s[ST_COUNT+:4] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_periph_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; reset empties the FIFO by clearing pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter and frame FSM.
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  uart_addr,
    input  logic        uart_wen,
    input  logic [31:0] uart_wdata,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    output logic        uart_txd
);

    localparam int unsigned DIV  = CLK_HZ / BAUD;
    localparam int unsigned CW   = $clog2(DIV);
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;

    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_rdata;
    logic [CNTW-1:0] fifo_count;
    logic           sel_txdata, sel_status, busy, last;
    logic           unused_ok;

    assign sel_txdata = (uart_addr[3:2] == UART_TXDATA[3:2]);
    assign sel_status = (uart_addr[3:2] == UART_STATUS[3:2]);
    assign fifo_push  = uart_wen && sel_txdata;
    assign uart_ready = !(fifo_full && sel_txdata);
    assign busy       = (state_q != TX_IDLE) || !fifo_empty;
    assign uart_rdata = sel_status ? pack_status(busy, fifo_full, fifo_empty, 4'(fifo_count)) : '0;
    assign last       = (cnt_q == CW'(DIV - 1));
    assign unused_ok  = ^{uart_wdata[31:8], uart_addr[1:0]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (uart_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        fifo_pop = 1'b0;
        uart_txd = 1'b1;
        unique case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                uart_txd = 1'b0;
                if (last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                uart_txd = shreg_q[0];
                if (last) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                // Popping on the final stop cycle chains the next frame with no idle gap.
                if (last) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                        state_d  = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph at DIV=4: register map, frame timing, FIFO back-pressure, reset abort.
module tb_uart_tx_periph;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  uart_addr;
    logic        uart_wen;
    logic [31:0] uart_wdata;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_txd;

    int n_total = 0;
    int n_pass  = 0;

    uart_tx_periph #(
        .CLK_HZ     (1_000_000),
        .BAUD       (250_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_addr  (uart_addr),
        .uart_wen   (uart_wen),
        .uart_wdata (uart_wdata),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .uart_txd   (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic setaddr(input logic [3:0] a);
        uart_addr = a;
        #1;
    endtask

    // Checks txd over frame cycles [from, to) of byte d, one sample per cycle, 4 cycles per bit.
    task automatic frame(input logic [7:0] d, input int from, input int to);
        logic exp_bit;
        for (int c = from; c < to; c++) begin
            int b;
            b = c / 4;
            if (b == 0)      exp_bit = 1'b0;
            else if (b == 9) exp_bit = 1'b1;
            else             exp_bit = d[b-1];
            chk($sformatf("txd byte %h cyc %0d", d, c), {31'b0, uart_txd}, {31'b0, exp_bit});
            @(negedge clk);
        end
    endtask

    initial begin
        rst        = 1'b1;
        uart_addr  = 4'h4;
        uart_wen   = 1'b0;
        uart_wdata = '0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst status", uart_rdata, 32'h004);
        chk("rst txd", {31'b0, uart_txd}, 32'h1);
        chk("rst ready", {31'b0, uart_ready}, 32'h1);
        setaddr(4'h0);
        chk("rst txdata read", uart_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single frame 0x55, two-cycle write-to-start latency
        uart_addr = 4'h0; uart_wen = 1'b1; uart_wdata = 32'hDEAD_BE55;
        @(negedge clk);
        uart_wen = 1'b0;
        chk("0x55 txd before pop", {31'b0, uart_txd}, 32'h1);
        setaddr(4'h4);
        chk("0x55 status after push", uart_rdata, 32'h101);
        @(negedge clk);
        chk("0x55 status after pop", uart_rdata, 32'h005);
        frame(8'h55, 0, 40);
        chk("0x55 busy cleared", uart_rdata, 32'h004);

        // Back-to-back frames 0x00, 0xFF
        uart_addr = 4'h0; uart_wen = 1'b1; uart_wdata = 32'h00;
        @(negedge clk);
        uart_wdata = 32'hFF;
        @(negedge clk);
        uart_wen = 1'b0;
        frame(8'h00, 0, 40);
        frame(8'hFF, 0, 40);
        setaddr(4'h4);
        chk("b2b idle status", uart_rdata, 32'h004);

        // Five writes while busy: FIFO fills, stall, defensive push ignored
        uart_addr = 4'h0; uart_wen = 1'b1; uart_wdata = 32'h11;
        @(negedge clk); uart_wdata = 32'h22;
        @(negedge clk); uart_wdata = 32'h33;
        @(negedge clk); uart_wdata = 32'h44;
        @(negedge clk); uart_wdata = 32'h55;
        @(negedge clk);
        uart_wdata = 32'h99;
        #1;
        chk("full ready@0", {31'b0, uart_ready}, 32'h0);
        @(negedge clk);
        uart_wen = 1'b0;
        setaddr(4'h4);
        chk("full ready@4", {31'b0, uart_ready}, 32'h1);
        chk("full status", uart_rdata, 32'h403);
        frame(8'h11, 4, 39);
        setaddr(4'h0);
        chk("stall last stop cyc", {31'b0, uart_ready}, 32'h0);
        frame(8'h11, 39, 40);
        chk("stall released", {31'b0, uart_ready}, 32'h1);
        setaddr(4'h4);
        chk("status after pop2", uart_rdata, 32'h301);
        frame(8'h22, 0, 40);
        frame(8'h33, 0, 40);
        frame(8'h44, 0, 40);
        frame(8'h55, 0, 40);
        chk("five drained status", uart_rdata, 32'h004);
        chk("five drained txd", {31'b0, uart_txd}, 32'h1);

        // Reset mid-DATA of 0xA5 with two bytes queued
        uart_addr = 4'h0; uart_wen = 1'b1; uart_wdata = 32'hA5;
        @(negedge clk); uart_wdata = 32'h01;
        @(negedge clk); uart_wdata = 32'h02;
        @(negedge clk);
        uart_wen = 1'b0;
        setaddr(4'h4);
        chk("a5 queued status", uart_rdata, 32'h201);
        frame(8'hA5, 1, 20);
        rst = 1'b1;
        #1;
        chk("abort txd", {31'b0, uart_txd}, 32'h1);
        chk("abort status", uart_rdata, 32'h004);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            chk($sformatf("post-abort txd %0d", i), {31'b0, uart_txd}, 32'h1);
        end
        chk("post-abort status", uart_rdata, 32'h004);

        // Reserved offsets and ignored address LSBs
        uart_addr = 4'h8; uart_wen = 1'b1; uart_wdata = 32'h77;
        #1;
        chk("ready@8", {31'b0, uart_ready}, 32'h1);
        @(negedge clk);
        uart_wen = 1'b0;
        setaddr(4'h4);
        chk("reserved write no push", uart_rdata, 32'h004);
        setaddr(4'h8);
        chk("read 0x8", uart_rdata, 32'h0);
        setaddr(4'hC);
        chk("read 0xC", uart_rdata, 32'h0);
        setaddr(4'h5);
        chk("read 0x5 aliases status", uart_rdata, 32'h004);
        @(negedge clk);
        @(negedge clk);
        chk("reserved txd idle", {31'b0, uart_txd}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
